// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request, load result and data-RAM signals of the load/store unit.
interface load_store_unit_if #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  REQ_VALID;
    logic                  REQ_WE;
    logic [2:0]            REQ_FUNCT3;
    logic [SIZE-1:0]       REQ_ADDR;
    logic [SIZE-1:0]       REQ_WDATA;
    logic                  STALL;
    logic [SIZE-1:0]       RDATA;
    logic                  RDATA_VALID;
    logic                  MISALIGNED;
    logic [ADDR_WIDTH-1:0] ADDR_RAM;
    logic [SIZE-1:0]       Q_RAM;
    logic [SIZE-1:0]       Q_W;
    logic                  ENABLE_W;

    modport master (
        output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, Q_RAM,
        input  STALL, RDATA, RDATA_VALID, MISALIGNED, ADDR_RAM, Q_W, ENABLE_W
    );
    modport slave (
        input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, Q_RAM,
        output STALL, RDATA, RDATA_VALID, MISALIGNED, ADDR_RAM, Q_W, ENABLE_W
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores onto a word-wide synchronous RAM.
module load_store_unit #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10
) (
    input logic               CLK,
    input logic               RESET_N,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD_DATA, RMW_READ, RMW_WRITE} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0] lane_q;
    logic [2:0] f3_q;
    logic [SIZE-1:0] wdata_q, merged_q, merged, mask, load_ext, shifted;
    logic [15:0] half;
    logic [4:0] sh;
    logic bad;
    logic unused_addr;
    assign unused_addr = &{1'b0, bus.REQ_ADDR[SIZE-1:ADDR_WIDTH+2]};
    assign bad = (bus.REQ_WE ? bus.REQ_FUNCT3 >= 3'd3 : (bus.REQ_FUNCT3 == 3'd3 || bus.REQ_FUNCT3 >= 3'd6))
               || (bus.REQ_FUNCT3[1:0] == 2'd1 && bus.REQ_ADDR[0])
               || (bus.REQ_FUNCT3[1:0] == 2'd2 && bus.REQ_ADDR[1:0] != 2'd0);
    // Load lanes: funct3[2] selects zero extension, funct3[1:0] the access size.
    assign shifted = bus.Q_RAM >> {lane_q, 3'b000};
    assign half = lane_q[1] ? bus.Q_RAM[31:16] : bus.Q_RAM[15:0];
    assign load_ext = f3_q[1] ? bus.Q_RAM
                    : f3_q[0] ? {{(SIZE-16){~f3_q[2] & half[15]}}, half}
                    : {{(SIZE-8){~f3_q[2] & shifted[7]}}, shifted[7:0]};
    assign sh = f3_q[0] ? {lane_q[1], 4'b0000} : {lane_q, 3'b000};
    assign mask = (f3_q[0] ? SIZE'(16'hFFFF) : SIZE'(8'hFF)) << sh;
    assign merged = (bus.Q_RAM & ~mask) | ((wdata_q << sh) & mask);
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            addr_q   <= '0;
            lane_q   <= '0;
            f3_q     <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                addr_q  <= bus.REQ_ADDR[ADDR_WIDTH+1:2];
                lane_q  <= bus.REQ_ADDR[1:0];
                f3_q    <= bus.REQ_FUNCT3;
                wdata_q <= bus.REQ_WDATA;
            end
            if (state == RMW_READ) merged_q <= merged;
        end
    end
    always_comb begin
        state_nx        = state;
        bus.STALL       = 1'b0;
        bus.RDATA       = '0;
        bus.RDATA_VALID = 1'b0;
        bus.MISALIGNED  = 1'b0;
        bus.ADDR_RAM    = addr_q;
        bus.Q_W         = '0;
        bus.ENABLE_W    = 1'b0;
        case (state)
            IDLE: begin
                bus.ADDR_RAM = bus.REQ_ADDR[ADDR_WIDTH+1:2];
                if (bus.REQ_VALID) begin
                    if (bad) bus.MISALIGNED = 1'b1;
                    else if (!bus.REQ_WE) begin
                        bus.STALL = 1'b1;
                        state_nx  = LOAD_DATA;
                    end else if (bus.REQ_FUNCT3[1]) begin
                        bus.ENABLE_W = 1'b1;
                        bus.Q_W      = bus.REQ_WDATA;
                    end else begin
                        bus.STALL = 1'b1;
                        state_nx  = RMW_READ;
                    end
                end
            end
            LOAD_DATA: begin
                bus.RDATA_VALID = bus.REQ_VALID;
                bus.RDATA       = bus.REQ_VALID ? load_ext : '0;
                state_nx        = IDLE;
            end
            RMW_READ: begin
                bus.STALL = bus.REQ_VALID;
                state_nx  = bus.REQ_VALID ? RMW_WRITE : IDLE;
            end
            default: begin
                bus.ENABLE_W = 1'b1;
                bus.Q_W      = merged_q;
                state_nx     = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed accesses against a RAM model and a transaction-level golden memory.
module tb_load_store_unit;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    load_store_unit_if #(.SIZE(32), .ADDR_WIDTH(10)) bus ();
    load_store_unit #(.SIZE(32), .ADDR_WIDTH(10)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus.slave));

    logic [31:0] ram [0:1023];
    logic [31:0] gm [0:1023];
    always @(posedge CLK) begin
        if (bus.ENABLE_W) ram[bus.ADDR_RAM] <= bus.Q_W;
        bus.Q_RAM <= ram[bus.ADDR_RAM];
    end

    int checks = 0;
    int errors = 0;
    logic chk_on = 1'b0;
    logic exp_stall, exp_valid, exp_mis, exp_we;
    logic [31:0] exp_rdata, exp_qw;
    logic [9:0] exp_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) if (chk_on) begin
        check("STALL", 32'(bus.STALL), 32'(exp_stall));
        check("RDATA_VALID", 32'(bus.RDATA_VALID), 32'(exp_valid));
        check("MISALIGNED", 32'(bus.MISALIGNED), 32'(exp_mis));
        check("ENABLE_W", 32'(bus.ENABLE_W), 32'(exp_we));
        check("RDATA", bus.RDATA, exp_rdata);
        check("ADDR_RAM", 32'(bus.ADDR_RAM), 32'(exp_addr));
        if (exp_we) check("Q_W", bus.Q_W, exp_qw);
    end

    // Golden memory view: byte lanes picked with arithmetic, not masks.
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] w, v;
        int k;
        w = gm[addr[11:2]];
        k = int'(addr[1:0]);
        if (f3 == 3'd2) return w;
        if (f3[0]) begin
            v = (w >> (addr[1] ? 16 : 0)) % 32'h10000;
            if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = (w >> (8 * k)) % 32'h100;
            if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFFFF00;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_val(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] w;
        int n;
        w = gm[addr[11:2]];
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) w[8*(int'(addr[1:0])+i) +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    task automatic clear_exp(input logic [31:0] addr);
        exp_stall = 0; exp_valid = 0; exp_mis = 0; exp_we = 0;
        exp_rdata = 0; exp_qw = 0; exp_addr = addr[11:2];
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        bus.REQ_VALID = v; bus.REQ_WE = we; bus.REQ_FUNCT3 = f3; bus.REQ_ADDR = addr; bus.REQ_WDATA = wd;
    endtask

    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input logic has_lit, input logic [31:0] lit);
        logic bad;
        bad = (we ? f3 >= 3 : (f3 == 3 || f3 >= 6)) || (f3[1:0] == 1 && addr[0]) || (f3[1:0] == 2 && addr[1:0] != 0);
        drive(1'b1, we, f3, addr, wd);
        clear_exp(addr);
        if (bad) begin
            exp_mis = 1;
            step();
        end else if (!we) begin
            exp_stall = 1;
            step();
            exp_stall = 0; exp_valid = 1; exp_rdata = load_val(f3, addr);
            if (has_lit) begin @(negedge CLK); check("literal RDATA", bus.RDATA, lit); end
            step();
        end else if (f3 == 3'd2) begin
            exp_we = 1; exp_qw = wd;
            step();
            gm[addr[11:2]] = wd;
        end else begin
            exp_stall = 1;
            step();
            step();
            exp_stall = 0; exp_we = 1; exp_qw = store_val(f3, addr, wd);
            if (has_lit) begin @(negedge CLK); check("literal Q_W", bus.Q_W, lit); end
            step();
            gm[addr[11:2]] = exp_qw;
        end
        bus.REQ_VALID = 0;
        clear_exp(addr);
        step();
    endtask

    task automatic ram_chk(input int w);
        check($sformatf("RAM[%0d]", w), ram[w], gm[w]);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin ram[i] = 32'(i) * 32'h01010101; gm[i] = ram[i]; end
        ram[4] = 32'h8899AABB; gm[4] = 32'h8899AABB;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        clear_exp(32'h0);
        chk_on = 1;
        step();
        step();
        RESET_N = 1;
        step();
        // Loads with sign and zero extension
        access(0, 3'd0, 32'h13, 0, 1, 32'hFFFFFF88);
        access(0, 3'd4, 32'h13, 0, 1, 32'h00000088);
        access(0, 3'd1, 32'h10, 0, 1, 32'hFFFFAABB);
        access(0, 3'd5, 32'h12, 0, 1, 32'h00008899);
        access(0, 3'd0, 32'h10, 0, 1, 32'hFFFFFFBB);
        access(0, 3'd4, 32'h11, 0, 1, 32'h000000AA);
        // SW, then read back
        access(1, 3'd2, 32'h20, 32'hDEADBEEF, 0, 0);
        ram_chk(8);
        access(0, 3'd2, 32'h20, 0, 1, 32'hDEADBEEF);
        // Sub-word read-modify-write
        access(1, 3'd2, 32'h20, 32'h11223344, 0, 0);
        access(1, 3'd0, 32'h21, 32'h000000AB, 1, 32'h1122AB44);
        access(1, 3'd1, 32'h22, 32'h0000CDEF, 1, 32'hCDEFAB44);
        ram_chk(8);
        access(1, 3'd0, 32'h23, 32'hFFFFFF5A, 1, 32'h5AEFAB44);
        access(1, 3'd1, 32'h20, 32'h12349876, 1, 32'h5AEF9876);
        access(0, 3'd2, 32'h20, 0, 1, 32'h5AEF9876);
        // Illegal and misaligned requests
        access(0, 3'd2, 32'h22, 0, 0, 0);
        access(1, 3'd1, 32'h23, 32'hFFFF, 0, 0);
        access(0, 3'd3, 32'h10, 0, 0, 0);
        access(1, 3'd3, 32'h20, 32'h1, 0, 0);
        access(0, 3'd6, 32'h10, 0, 0, 0);
        ram_chk(8);
        ram_chk(4);
        // Address wrap: upper address bits ignored
        access(0, 3'd2, 32'hFFFF_F010, 0, 1, 32'h8899AABB);
        // Request dropped in LOAD_DATA
        drive(1'b1, 1'b0, 3'd0, 32'h13, 0);
        clear_exp(32'h13); exp_stall = 1;
        step();
        bus.REQ_VALID = 0; clear_exp(32'h13);
        step();
        step();
        // Request dropped in RMW_READ: no write may follow
        drive(1'b1, 1'b1, 3'd0, 32'h21, 32'h77);
        clear_exp(32'h21); exp_stall = 1;
        step();
        bus.REQ_VALID = 0; clear_exp(32'h21);
        step();
        step();
        ram_chk(8);
        // Asynchronous reset in RMW_READ
        drive(1'b1, 1'b1, 3'd0, 32'h22, 32'h99);
        clear_exp(32'h22); exp_stall = 1;
        step();
        #2;
        RESET_N = 0; bus.REQ_VALID = 0; clear_exp(32'h22);
        step();
        RESET_N = 1;
        step();
        ram_chk(8);
        access(0, 3'd2, 32'h20, 0, 1, 32'h5AEF9876);
        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
